// File: rtl/jtag_tap_sampled.sv
// -----------------------------------------------------------------------------
// jtag_tap_sampled
//
// Target-side IEEE 1149.1 TAP controller whose JTAG pins are oversampled in the
// system clock domain. A slow, bit-banged TCK from a USB bridge is synchronized
// and edge-detected, and the 16-state TAP FSM, the instruction register and the
// BYPASS / IDCODE / USER data registers all advance on the detected edges.
// The USER register acts as a read/write mailbox between the host and fabric.
//
// Ports:
//   clk, rst_i         system clock, asynchronous active-high reset
//   tck, tms, tdi      JTAG inputs, asynchronous to clk
//   trst               JTAG test reset, active-high, asynchronous
//   tdo, tdo_en        JTAG data out (changes on TCK fall), enable in Shift-IR/DR
//   user_dr_i          value captured into USER in Capture-DR
//   user_dr_o          last value written through USER in Update-DR
//   user_update_o      one-clk pulse when user_dr_o is written
//   user_capture_o     one-clk pulse when user_dr_i is sampled
//   tap_state_o        current TAP state encoding
//   ir_o               current instruction
// -----------------------------------------------------------------------------
module jtag_tap_sampled #(
   parameter int                 IR_WIDTH     = 4,
   parameter int                 USER_WIDTH   = 32,
   parameter logic [31:0]        IDCODE_VALUE = 32'h1000_0FAB,
   parameter logic [IR_WIDTH-1:0] INSTR_IDCODE = IR_WIDTH'(4'h1),
   parameter logic [IR_WIDTH-1:0] INSTR_USER   = IR_WIDTH'(4'h8)
) (
   input  logic                  clk,
   input  logic                  rst_i,
   input  logic                  tck,
   input  logic                  tms,
   input  logic                  tdi,
   input  logic                  trst,
   output logic                  tdo,
   output logic                  tdo_en,
   input  logic [USER_WIDTH-1:0] user_dr_i,
   output logic [USER_WIDTH-1:0] user_dr_o,
   output logic                  user_update_o,
   output logic                  user_capture_o,
   output logic [3:0]            tap_state_o,
   output logic [IR_WIDTH-1:0]   ir_o
);

   typedef enum logic [3:0] {
      TLR     = 4'hF,
      RTI     = 4'hC,
      SEL_DR  = 4'h7,
      CAP_DR  = 4'h6,
      SH_DR   = 4'h2,
      EX1_DR  = 4'h1,
      PAUSE_DR = 4'h3,
      EX2_DR  = 4'h0,
      UPD_DR  = 4'h5,
      SEL_IR  = 4'h4,
      CAP_IR  = 4'hE,
      SH_IR   = 4'hA,
      EX1_IR  = 4'h9,
      PAUSE_IR = 4'hB,
      EX2_IR  = 4'h8,
      UPD_IR  = 4'hD
   } tap_state_e;

   typedef enum logic [1:0] {
      SEL_BYPASS,
      SEL_IDCODE,
      SEL_USER
   } dr_sel_e;

   // ---------------------------------------------------------------------------
   // Synchronizers: two flops per pin, plus a third on tck for edge detection.
   // ---------------------------------------------------------------------------
   logic [1:0] tck_sync_q, tck_sync_d;
   logic [1:0] tms_sync_q, tms_sync_d;
   logic [1:0] tdi_sync_q, tdi_sync_d;
   logic [1:0] trst_sync_q, trst_sync_d;
   logic       tck_prev_q, tck_prev_d;

   always_comb begin
      tck_sync_d  = {tck_sync_q[0], tck};
      tms_sync_d  = {tms_sync_q[0], tms};
      tdi_sync_d  = {tdi_sync_q[0], tdi};
      trst_sync_d = {trst_sync_q[0], trst};
      tck_prev_d  = tck_sync_q[1];
   end

   logic tck_rise, tck_fall, tms_s, tdi_s, trst_s;

   assign tck_rise = tck_sync_q[1] & ~tck_prev_q;
   assign tck_fall = ~tck_sync_q[1] & tck_prev_q;
   assign tms_s    = tms_sync_q[1];
   assign tdi_s    = tdi_sync_q[1];
   assign trst_s   = trst_sync_q[1];

   // ---------------------------------------------------------------------------
   // State and register declarations
   // ---------------------------------------------------------------------------
   tap_state_e            state_q, state_d, tap_next;
   logic [IR_WIDTH-1:0]   ir_q, ir_d;
   logic [IR_WIDTH-1:0]   ir_shift_q, ir_shift_d;
   logic [31:0]           idcode_shift_q, idcode_shift_d;
   logic                  bypass_q, bypass_d;
   logic [USER_WIDTH-1:0] user_shift_q, user_shift_d;
   logic [USER_WIDTH-1:0] user_dr_q, user_dr_d;
   logic                  user_update_q, user_update_d;
   logic                  user_capture_q, user_capture_d;
   logic                  tdo_q, tdo_d;
   dr_sel_e               dr_sel;

   // Any opcode other than IDCODE or USER (including all-ones) selects BYPASS.
   always_comb begin
      if (ir_q == INSTR_IDCODE)    dr_sel = SEL_IDCODE;
      else if (ir_q == INSTR_USER) dr_sel = SEL_USER;
      else                         dr_sel = SEL_BYPASS;
   end

   // ---------------------------------------------------------------------------
   // TAP next-state table (evaluated every cycle, applied only on tck_rise)
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no
      // path through the case statements can leave it unassigned (no latch).
      tap_next = state_q;
      case (state_q)
         TLR:      tap_next = tms_s ? TLR    : RTI;
         RTI:      tap_next = tms_s ? SEL_DR : RTI;
         SEL_DR:   tap_next = tms_s ? SEL_IR : CAP_DR;
         CAP_DR:   tap_next = tms_s ? EX1_DR : SH_DR;
         SH_DR:    tap_next = tms_s ? EX1_DR : SH_DR;
         EX1_DR:   tap_next = tms_s ? UPD_DR : PAUSE_DR;
         PAUSE_DR: tap_next = tms_s ? EX2_DR : PAUSE_DR;
         EX2_DR:   tap_next = tms_s ? UPD_DR : SH_DR;
         UPD_DR:   tap_next = tms_s ? SEL_DR : RTI;
         SEL_IR:   tap_next = tms_s ? TLR    : CAP_IR;
         CAP_IR:   tap_next = tms_s ? EX1_IR : SH_IR;
         SH_IR:    tap_next = tms_s ? EX1_IR : SH_IR;
         EX1_IR:   tap_next = tms_s ? UPD_IR : PAUSE_IR;
         PAUSE_IR: tap_next = tms_s ? EX2_IR : PAUSE_IR;
         EX2_IR:   tap_next = tms_s ? UPD_IR : SH_IR;
         UPD_IR:   tap_next = tms_s ? SEL_DR : RTI;
         default:  tap_next = TLR;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Register next-state: captures/shifts on tck_rise, updates/tdo on tck_fall
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d        = state_q;
      ir_d           = ir_q;
      ir_shift_d     = ir_shift_q;
      idcode_shift_d = idcode_shift_q;
      bypass_d       = bypass_q;
      user_shift_d   = user_shift_q;
      user_dr_d      = user_dr_q;
      tdo_d          = tdo_q;
      user_update_d  = 1'b0;
      user_capture_d = 1'b0;

      if (trst_s) begin
         // Test reset wins over any edge seen in the same cycle.
         state_d = TLR;
         ir_d    = INSTR_IDCODE;
      end else if (tck_rise) begin
         state_d = tap_next;
         // ir is also reset on the rise that enters TLR, so it already reads
         // IDCODE once five TMS-high clocks have been applied.
         if (state_q == TLR || tap_next == TLR) begin
            ir_d = INSTR_IDCODE;
         end
         case (state_q)
            CAP_IR: ir_shift_d = IR_WIDTH'(1);
            SH_IR:  ir_shift_d = {tdi_s, ir_shift_q[IR_WIDTH-1:1]};
            CAP_DR: begin
               case (dr_sel)
                  SEL_IDCODE: idcode_shift_d = IDCODE_VALUE;
                  SEL_USER: begin
                     user_shift_d   = user_dr_i;
                     user_capture_d = 1'b1;
                  end
                  default: bypass_d = 1'b0;
               endcase
            end
            SH_DR: begin
               case (dr_sel)
                  SEL_IDCODE: idcode_shift_d = {tdi_s, idcode_shift_q[31:1]};
                  // Written as shift-and-or so a 1-bit USER register works.
                  SEL_USER: user_shift_d = (user_shift_q >> 1)
                                         | (USER_WIDTH'(tdi_s) << (USER_WIDTH - 1));
                  default: bypass_d = tdi_s;
               endcase
            end
            default: ;
         endcase
      end else if (tck_fall) begin
         case (state_q)
            UPD_IR: ir_d = ir_shift_q;
            UPD_DR: begin
               if (dr_sel == SEL_USER) begin
                  user_dr_d     = user_shift_q;
                  user_update_d = 1'b1;
               end
            end
            SH_IR: tdo_d = ir_shift_q[0];
            SH_DR: begin
               case (dr_sel)
                  SEL_IDCODE: tdo_d = idcode_shift_q[0];
                  SEL_USER:   tdo_d = user_shift_q[0];
                  default:    tdo_d = bypass_q;
               endcase
            end
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Flops
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst_i) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the values from before this edge, regardless of statement order.
      if (rst_i) begin
         tck_sync_q     <= '0;
         tms_sync_q     <= '0;
         tdi_sync_q     <= '0;
         trst_sync_q    <= '0;
         tck_prev_q     <= 1'b0;
         state_q        <= TLR;
         ir_q           <= INSTR_IDCODE;
         ir_shift_q     <= '0;
         idcode_shift_q <= '0;
         bypass_q       <= 1'b0;
         user_shift_q   <= '0;
         user_dr_q      <= '0;
         user_update_q  <= 1'b0;
         user_capture_q <= 1'b0;
         tdo_q          <= 1'b0;
      end else begin
         tck_sync_q     <= tck_sync_d;
         tms_sync_q     <= tms_sync_d;
         tdi_sync_q     <= tdi_sync_d;
         trst_sync_q    <= trst_sync_d;
         tck_prev_q     <= tck_prev_d;
         state_q        <= state_d;
         ir_q           <= ir_d;
         ir_shift_q     <= ir_shift_d;
         idcode_shift_q <= idcode_shift_d;
         bypass_q       <= bypass_d;
         user_shift_q   <= user_shift_d;
         user_dr_q      <= user_dr_d;
         user_update_q  <= user_update_d;
         user_capture_q <= user_capture_d;
         tdo_q          <= tdo_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign tdo            = tdo_q;
   assign tdo_en         = (state_q == SH_IR) || (state_q == SH_DR);
   assign user_dr_o      = user_dr_q;
   assign user_update_o  = user_update_q;
   assign user_capture_o = user_capture_q;
   assign tap_state_o    = state_q;
   assign ir_o           = ir_q;

endmodule

// File: doc/jtag_tap_sampled.md
Name: jtag_tap_sampled

Overview:
- Target-side JTAG TAP controller. It is the responder for the host-driven USB-to-JTAG bitbang bridge, which drives tck/tms/tdi/trst and samples tdo.
- Oversamples the slow bit-banged TCK in the system clock domain.
- Runs the IEEE 1149.1 16-state TAP FSM with an instruction register, BYPASS, IDCODE and one USER data register.
- The USER register gives fabric logic a read/write mailbox reachable over the same USB link.

Parameters:
- IR_WIDTH, 4, instruction register width (min 2).
- USER_WIDTH, 32, USER data register width (min 1).
- IDCODE_VALUE, 32'h1000_0FAB, IDCODE register contents; bit 0 must be 1.
- INSTR_IDCODE, 4'h1, IDCODE opcode.
- INSTR_USER, 4'h8, USER opcode; all-ones is BYPASS.

Ports:
- clk  in  1  system clock
- rst_i  in  1  async active-high reset
- tck  in  1  JTAG clock, asynchronous to clk
- tms  in  1  JTAG mode select, async
- tdi  in  1  JTAG data in, async
- trst  in  1  JTAG test reset, active-high, async
- tdo  out  1  JTAG data out
- tdo_en  out  1  high while in Shift-IR or Shift-DR
- user_dr_i  in  USER_WIDTH  value loaded in Capture-DR when USER is selected
- user_dr_o  out  USER_WIDTH  last value updated through USER
- user_update_o  out  1  one-clk pulse when user_dr_o changes
- user_capture_o  out  1  one-clk pulse when user_dr_i is sampled
- tap_state_o  out  4  current TAP state encoding
- ir_o  out  IR_WIDTH  current instruction

Behaviour:
- Reset values (rst_i asserted):
  - tdo=0, tdo_en=0, user_dr_o=0, both pulses=0.
  - tap_state_o=Test-Logic-Reset, ir_o=INSTR_IDCODE.
  - All shift registers and synchronizers cleared.
- Synchronization:
  - tck, tms, tdi and trst each pass through 2 flops.
  - A third flop on tck holds the previous value.
  - tck_rise = sync & ~prev; tck_fall = ~sync & prev.
  - Pin edge to registered effect is 3 clk edges.
  - The host must keep tck high and low for at least 4 clk cycles each. Narrower pulses are undefined and need not be detected.
- trst: while synchronized trst=1, force Test-Logic-Reset and ir=INSTR_IDCODE. user_dr_o keeps its value. This overrides any tck_rise in the same cycle.
- FSM advances only on tck_rise, per the standard TMS transition table:
  - TLR, RTI, SelDR, CapDR, ShDR, Ex1DR, PauseDR, Ex2DR, UpdDR.
  - SelIR, CapIR, ShIR, Ex1IR, PauseIR, Ex2IR, UpdIR.
  - Encoding: TLR=0xF, RTI=0xC, SelDR=0x7, CapDR=0x6, ShDR=0x2, Ex1DR=0x1, PauseDR=0x3, Ex2DR=0x0, UpdDR=0x5, SelIR=0x4, CapIR=0xE, ShIR=0xA, Ex1IR=0x9, PauseIR=0xB, Ex2IR=0x8, UpdIR=0xD.
  - Five tck rises with tms=1 reach TLR from any state.
- On tck_rise, by state before the transition:
  - CapIR: ir_shift <= {0..0,01}.
  - ShIR: ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]} (LSB first).
  - CapDR: load the selected DR.
    - IDCODE: IDCODE_VALUE.
    - BYPASS: 0.
    - USER: user_dr_i, and pulse user_capture_o that clk.
  - ShDR: shift the selected DR right, tdi entering at the MSB.
  - TLR: ir <= INSTR_IDCODE.
- UpdIR: ir <= ir_shift, on the tck_fall while in UpdIR.
- UpdDR with USER selected: on tck_fall, user_dr_o <= shift contents and pulse user_update_o for exactly 1 clk.
- Opcodes other than IDCODE and USER select BYPASS.
- tdo updates on tck_fall only:
  - ShIR: ir_shift[0].
  - ShDR: selected DR [0].
  - Otherwise tdo holds its value.
  - tdo_en is driven combinationally from state (ShIR or ShDR).
- The first tdo bit after Capture is valid before the first shifting rising edge, because Capture→Shift happens on a rise and the following fall drives bit 0.
- Simultaneous tck_rise and tck_fall cannot occur; the design needs no arbitration for it.
- rst_i mid-shift: immediate return to reset values. Partial shifts are discarded, and user_dr_o is not updated.

Test Plan:
- Reset, then tms=0 to ShDR and shift 32 bits → tdo returns 0x10000FAB LSB first; no user pulses.
- From ShDR, apply 5 tck with tms=1 → tap_state_o=0xF, ir_o=0x1.
- Load IR 0xF (BYPASS), then shift tdi pattern 1,0,1,1 → tdo yields 0,1,0,1 (one-bit delay, leading 0 from capture).
- Load IR 0x8 and shift in 0xDEADBEEF → exactly one user_update_o pulse on UpdDR fall, user_dr_o=0xDEADBEEF; IR shift-out captured 0b0001.
- With user_dr_i=0x12345678 and IR=USER, pass through CapDR → user_capture_o pulses once; shifted tdo=0x12345678.
- Assert trst mid-ShDR → TLR within 3 clk, ir_o=0x1, user_dr_o unchanged. Repeat with rst_i → all outputs at reset values on the same edge.
